spi_slave_if: RTL

- SPI target (slave) endpoint: the far end of the APB-to-SPI master (spi_top).
- Receives sclk, ss_n and mosi, drives miso, and exchanges WIDTH-bit frames with local logic through a parallel TX-buffer/RX-register handshake.
- Runs entirely in the PCLK domain by oversampling the serial inputs.
- Used as the on-chip loopback/bench counterpart of spi_top and as a reusable peripheral-side SPI port.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_edge_det.sv | 78 +++++++
 rtl/spi_slave_if.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encoding, default frame width, slave FSM states.
package spi_pkg;

    localparam int unsigned SPI_DEFAULT_WIDTH = 32;

    // SPI mode encoded as {CPOL, CPHA}
    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic {
        SPI_SLV_IDLE   = 1'b0,
        SPI_SLV_ACTIVE = 1'b1
    } spi_slv_state_e;

    function automatic logic mode_cpol(input spi_mode_e mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input spi_mode_e mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_edge_det.sv
// SPI input stage: optional 2-flop synchronizer (SPI_SLV_SYNC_EN), a 1-flop
// history, and combinational decode of sample/out clock edges and select edges.
module spi_edge_det
    import spi_pkg::*;
#(
    parameter spi_mode_e MODE = SPI_MODE0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic ss_n,
    input  logic mosi,
    output logic sample_edge,
    output logic out_edge,
    output logic ss_fall,
    output logic ss_rise,
    output logic mosi_s
);

    localparam logic POL = mode_cpol(MODE);
    localparam logic PHA = mode_cpha(MODE);

    logic sclk_now;
    logic ss_n_now;
    logic sclk_q;
    logic ss_n_q;
    logic lead;
    logic trail;

`ifdef SPI_SLV_SYNC_EN
    logic [1:0] sclk_sync;
    logic [1:0] ss_n_sync;
    logic [1:0] mosi_sync;

    // Two-flop synchronizers for an asynchronous master, reset to idle levels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= {2{POL}};
            ss_n_sync <= 2'b11;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            ss_n_sync <= {ss_n_sync[0], ss_n};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign sclk_now = sclk_sync[1];
    assign ss_n_now = ss_n_sync[1];
    assign mosi_s   = mosi_sync[1];
`else
    assign sclk_now = sclk;
    assign ss_n_now = ss_n;
    assign mosi_s   = mosi;
`endif

    // History flop holding last cycle's sclk and ss_n
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_q <= POL;
            ss_n_q <= 1'b1;
        end else begin
            sclk_q <= sclk_now;
            ss_n_q <= ss_n_now;
        end
    end

    // Edge decode: lead leaves the idle level, trail returns to it
    always_comb begin
        lead        = (sclk_now != POL) && (sclk_q == POL);
        trail       = (sclk_now == POL) && (sclk_q != POL);
        sample_edge = PHA ? trail : lead;
        out_edge    = PHA ? lead  : trail;
        ss_fall     = ss_n_q && !ss_n_now;
        ss_rise     = !ss_n_q && ss_n_now;
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave endpoint in the PCLK domain: oversamples sclk/ss_n/mosi, exchanges
// WIDTH-bit MSB-first frames via a TX buffer and RX register.
// SPI_SLV_SYNC_EN adds an input synchronizer for an asynchronous master.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int unsigned      WIDTH   = SPI_DEFAULT_WIDTH,
    parameter bit               CPOL    = 1'b0,
    parameter bit               CPHA    = 1'b0,
    parameter logic [WIDTH-1:0] IDLE_TX = '0
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             sclk,
    input  logic             ss_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             busy,
    output logic             rx_overrun,
    output logic             tx_underrun,
    output logic             frame_abort
);

    localparam int unsigned CW   = $clog2(WIDTH + 1);
    localparam spi_mode_e   MODE = spi_mode_e'({CPOL, CPHA});

    logic sample_edge;
    logic out_edge;
    logic ss_fall;
    logic ss_rise;
    logic mosi_s;

    spi_slv_state_e   state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] tx_buf, tx_buf_d;
    logic [WIDTH-1:0] tx_shift, tx_shift_d;
    logic [WIDTH-1:0] rx_shift, rx_shift_d;
    logic [WIDTH-1:0] rx_data_d;
    logic             tx_ready_d;
    logic             rx_valid_d;
    logic             miso_d;
    logic             miso_oe_d;
    logic             busy_d;
    logic             rx_overrun_d;
    logic             tx_underrun_d;
    logic             frame_abort_d;
    logic             frame_load;

    spi_edge_det #(
        .MODE(MODE)
    ) u_edge_det (
        .clk        (PCLK),
        .rst_n      (PRESETn),
        .sclk       (sclk),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .sample_edge(sample_edge),
        .out_edge   (out_edge),
        .ss_fall    (ss_fall),
        .ss_rise    (ss_rise),
        .mosi_s     (mosi_s)
    );

    // State and datapath registers; outputs registered from their next values
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state       <= SPI_SLV_IDLE;
            cnt         <= '0;
            tx_buf      <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            tx_ready    <= 1'b1;
            rx_valid    <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            tx_buf      <= tx_buf_d;
            tx_shift    <= tx_shift_d;
            rx_shift    <= rx_shift_d;
            rx_data     <= rx_data_d;
            tx_ready    <= tx_ready_d;
            rx_valid    <= rx_valid_d;
            miso        <= miso_d;
            miso_oe     <= miso_oe_d;
            busy        <= busy_d;
            rx_overrun  <= rx_overrun_d;
            tx_underrun <= tx_underrun_d;
            frame_abort <= frame_abort_d;
        end
    end

    // Next-state, frame shifting, buffer handshake and status pulses
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        tx_buf_d      = tx_buf;
        tx_shift_d    = tx_shift;
        rx_shift_d    = rx_shift;
        rx_data_d     = rx_data;
        tx_ready_d    = tx_ready;
        rx_valid_d    = rx_valid && !rx_ack;
        rx_overrun_d  = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;
        frame_load    = 1'b0;

        // Buffer accepts a word only while empty
        if (tx_load && tx_ready) begin
            tx_buf_d   = tx_data;
            tx_ready_d = 1'b0;
        end

        case (state)
            SPI_SLV_IDLE: begin
                if (ss_fall) begin
                    state_d    = SPI_SLV_ACTIVE;
                    cnt_d      = '0;
                    rx_shift_d = '0;
                    frame_load = 1'b1;
                end
            end
            SPI_SLV_ACTIVE: begin
                if (ss_rise) begin
                    state_d       = SPI_SLV_IDLE;
                    frame_abort_d = (cnt != '0);
                    cnt_d         = '0;
                    rx_shift_d    = '0;
                end else if (sample_edge) begin
                    rx_shift_d = {rx_shift[WIDTH-2:0], mosi_s};
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt_d        = '0;
                        rx_data_d    = rx_shift_d;
                        rx_valid_d   = 1'b1;
                        rx_overrun_d = rx_valid && !rx_ack;
                        frame_load   = 1'b1;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end else if (out_edge && (cnt != '0)) begin
                    // First out edge of a CPHA=1 frame keeps the preloaded MSB
                    tx_shift_d = {tx_shift[WIDTH-2:0], 1'b0};
                end
            end
            default: state_d = SPI_SLV_IDLE;
        endcase

        // Frame start or back-to-back reload: take the buffer, else the idle word
        if (frame_load) begin
            if (!tx_ready) begin
                tx_shift_d = tx_buf;
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d    = IDLE_TX;
                tx_underrun_d = 1'b1;
            end
        end

        miso_oe_d = (state_d == SPI_SLV_ACTIVE);
        miso_d    = (state_d == SPI_SLV_ACTIVE) && tx_shift_d[WIDTH-1];
        busy_d    = (cnt_d != '0);
    end

endmodule
